// File: rtl/proximity_events.sv
// Turns the ranger's near/mid/far level flags into a debounced zone code and the
// touch (near-hold) and approach (far->mid->near gesture) interaction pulses.
module proximity_events #(
  parameter int STABLE_CYCLES = 250000,
  parameter int HOLD_CYCLES   = 100000000,
  parameter int WINDOW_CYCLES = 75000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       level1,
  input  logic       level2,
  input  logic       level3,
  output logic [1:0] zone,
  output logic       zone_change,
  output logic       touch,
  output logic       approach,
  output logic [1:0] gesture_state
);

  localparam int DW = $clog2(STABLE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int WW = $clog2(WINDOW_CYCLES) + 1;

  localparam logic [DW-1:0] STABLE_V  = DW'(STABLE_CYCLES);
  localparam logic [HW-1:0] HOLD_V    = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW_CYCLES - 1);

  localparam logic [1:0] Z_NONE = 2'd0;
  localparam logic [1:0] Z_NEAR = 2'd1;
  localparam logic [1:0] Z_MID  = 2'd2;
  localparam logic [1:0] Z_FAR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAW_FAR = 2'd1,
    SAW_MID = 2'd2
  } gstate_t;

  // Stage p0/p1: two-flop synchroniser, bit 0 = near, bit 2 = far
  logic [2:0] sync_p0, sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 3'b000;
      sync_p1 <= 3'b000;
    end else begin
      sync_p0 <= {level3, level2, level1};
      sync_p1 <= sync_p0;
    end
  end

  // Nearest asserted band wins when the ranger reports several at once
  logic [1:0] decoded;

  always_comb begin
    decoded = Z_NONE;
    if (sync_p1[0])      decoded = Z_NEAR;
    else if (sync_p1[1]) decoded = Z_MID;
    else if (sync_p1[2]) decoded = Z_FAR;
  end

  // Stage p2: debounce candidate and accepted zone
  logic [1:0]    cand;
  logic [DW-1:0] dcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand        <= Z_NONE;
      dcnt        <= '0;
      zone        <= Z_NONE;
      zone_change <= 1'b0;
    end else begin
      if (decoded != cand) begin
        cand <= decoded;
        dcnt <= DW'(1);
      end else if (dcnt < STABLE_V) begin
        dcnt <= dcnt + DW'(1);
      end
      if (dcnt == STABLE_V && cand != zone) begin
        zone        <= cand;
        zone_change <= 1'b1;
      end else begin
        zone_change <= 1'b0;
      end
    end
  end

  // Touch hold: saturating counter so only one pulse per NEAR residency
  logic [HW-1:0] hcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt  <= '0;
      touch <= 1'b0;
    end else if (zone != Z_NEAR) begin
      hcnt  <= '0;
      touch <= 1'b0;
    end else begin
      if (hcnt < HOLD_V) hcnt <= hcnt + HW'(1);
      touch <= (hcnt == HOLD_LAST);
    end
  end

  // Approach gesture FSM
  gstate_t       state, state_next;
  logic [WW-1:0] wcnt, wcnt_next;
  logic          approach_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wcnt     <= '0;
      approach <= 1'b0;
    end else begin
      state    <= state_next;
      wcnt     <= wcnt_next;
      approach <= approach_next;
    end
  end

  // A qualifying zone change takes precedence over the window timeout
  always_comb begin
    state_next    = state;
    wcnt_next     = (state == IDLE) ? '0 : wcnt + WW'(1);
    approach_next = 1'b0;
    case (state)
      IDLE: begin
        if (zone_change && zone == Z_FAR) begin
          state_next = SAW_FAR;
          wcnt_next  = '0;
        end
      end
      SAW_FAR: begin
        if (zone_change) begin
          if (zone == Z_MID) state_next = SAW_MID;
          else               state_next = IDLE;
        end else if (wcnt == WIN_LAST) begin
          state_next = IDLE;
        end
      end
      SAW_MID: begin
        if (zone_change) begin
          if (zone == Z_NEAR) begin
            approach_next = 1'b1;
            state_next    = IDLE;
          end else if (zone == Z_FAR) begin
            state_next = SAW_FAR;
            wcnt_next  = '0;
          end else begin
            state_next = IDLE;
          end
        end else if (wcnt == WIN_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gesture_state = state;

endmodule

// File: tb/tb_proximity_events.sv
// Directed bench for proximity_events with short debounce, hold and window settings.
module tb_proximity_events;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       level1, level2, level3;
  logic [1:0] zone;
  logic       zone_change, touch, approach;
  logic [1:0] gesture_state;

  int checks   = 0;
  int failures = 0;

  proximity_events #(
    .STABLE_CYCLES(4),
    .HOLD_CYCLES  (20),
    .WINDOW_CYCLES(50)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .level1       (level1),
    .level2       (level2),
    .level3       (level3),
    .zone         (zone),
    .zone_change  (zone_change),
    .touch        (touch),
    .approach     (approach),
    .gesture_state(gesture_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_levels(input logic l1, input logic l2, input logic l3);
    level1 = l1;
    level2 = l2;
    level3 = l3;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    set_levels(1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      set_levels(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
      if ({zone, zone_change, touch, approach, gesture_state} !== 7'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_hold: nonzero output cycles=%0d required=0", bad);
    end
    set_levels(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (zone_change !== 1'b0 || zone !== 2'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_release: zone activity cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_debounce();
    int changes;
    set_levels(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (zone !== 2'd0 || zone_change !== 1'b0) begin
      failures++;
      $display("FAIL debounce_early: zone=%0d chg=%0b required zone=0 chg=0", zone, zone_change);
    end
    step();
    checks++;
    if (zone !== 2'd2 || zone_change !== 1'b1) begin
      failures++;
      $display("FAIL debounce_edge7: zone=%0d chg=%0b required zone=2 chg=1", zone, zone_change);
    end
    step();
    checks++;
    if (zone_change !== 1'b0) begin
      failures++;
      $display("FAIL debounce_pulse_width: chg=%0b required=0", zone_change);
    end
    changes = 0;
    level1 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) level1 = 1'b0;
      step();
      if (zone_change) changes++;
    end
    checks++;
    if (changes !== 0 || zone !== 2'd2) begin
      failures++;
      $display("FAIL glitch_reject: changes=%0d zone=%0d required changes=0 zone=2", changes, zone);
    end
  endtask

  task automatic touch_run(input string name);
    int count, first, apps;
    count = 0;
    first = -1;
    apps  = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (touch) begin
        count++;
        if (first < 0) first = i;
      end
      if (approach) apps++;
    end
    checks++;
    if (count !== 1 || first !== 27 || apps !== 0) begin
      failures++;
      $display("FAIL %s: touches=%0d at=%0d approaches=%0d required 1 at 27, 0 approaches",
               name, count, first, apps);
    end
  endtask

  task automatic test_touch();
    set_levels(1'b1, 1'b0, 1'b0);
    touch_run("touch_first");
    set_levels(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (zone !== 2'd0) begin
      failures++;
      $display("FAIL touch_release: zone=%0d required=0", zone);
    end
    set_levels(1'b1, 1'b0, 1'b0);
    touch_run("touch_rearm");
    set_levels(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step();
  endtask

  task automatic test_approach();
    int apps;
    apps = 0;
    set_levels(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 50; i++) begin
      step();
      if (approach) apps++;
      if (i == 8 && gesture_state !== 2'd1) begin
        failures++;
        $display("FAIL approach_saw_far: state=%0d required=1", gesture_state);
      end
      if (i == 20 && gesture_state !== 2'd2) begin
        failures++;
        $display("FAIL approach_saw_mid: state=%0d required=2", gesture_state);
      end
      if (i == 32 && (approach !== 1'b1 || zone !== 2'd1 || gesture_state !== 2'd0)) begin
        failures++;
        $display("FAIL approach_fire: approach=%0b zone=%0d state=%0d required 1,1,0",
                 approach, zone, gesture_state);
      end
      if (i == 12) set_levels(1'b0, 1'b1, 1'b0);
      if (i == 24) set_levels(1'b1, 1'b0, 1'b0);
      if (i == 36) set_levels(1'b0, 1'b0, 1'b0);
    end
    checks += 3;
    checks++;
    if (apps !== 1) begin
      failures++;
      $display("FAIL approach_count: approaches=%0d required=1", apps);
    end
  endtask

  task automatic test_timeout();
    int apps;
    apps = 0;
    set_levels(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 100; i++) begin
      step();
      if (approach) apps++;
      if (i == 57 && gesture_state !== 2'd1) begin
        failures++;
        $display("FAIL timeout_last_window: state=%0d required=1", gesture_state);
      end
      if (i == 58 && gesture_state !== 2'd0) begin
        failures++;
        $display("FAIL timeout_idle: state=%0d required=0", gesture_state);
      end
      if (i == 60) set_levels(1'b0, 1'b1, 1'b0);
      if (i == 72) set_levels(1'b1, 1'b0, 1'b0);
      if (i == 84) set_levels(1'b0, 1'b0, 1'b0);
    end
    checks += 2;
    checks++;
    if (apps !== 0) begin
      failures++;
      $display("FAIL timeout_no_approach: approaches=%0d required=0", apps);
    end
  endtask

  task automatic test_reset_abort();
    int touches;
    touches = 0;
    set_levels(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      step();
      if (touch) touches++;
      if (i == 7 && zone !== 2'd1) begin
        failures++;
        $display("FAIL abort_zone_near: zone=%0d required=1", zone);
      end
    end
    checks++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({zone, zone_change, touch, approach, gesture_state} !== 7'b0) begin
      failures++;
      $display("FAIL abort_immediate: zone=%0d chg=%0b touch=%0b app=%0b state=%0d required all 0",
               zone, zone_change, touch, approach, gesture_state);
    end
    set_levels(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (touch) touches++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (touch) touches++;
    end
    checks++;
    if (touches !== 0 || zone !== 2'd0) begin
      failures++;
      $display("FAIL abort_no_touch: touches=%0d zone=%0d required 0,0", touches, zone);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_touch();
    test_approach();
    test_timeout();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
